// File: rtl/ps2_key_buffer.sv
// PS/2 keyboard receiver: synchronises the raw pins, assembles 11-bit frames,
// drops break/E0 sequences and queues make codes for the key-read interface.
module ps2_key_buffer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       CLK_CPU,
    input  logic       resetp,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       clean_key_buffer,
    output logic [7:0] pressed_key,
    output logic       keyboard_valid,
    output logic       frame_error,
    output logic       overflow,
    output logic [1:0] rx_state_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    rx_state_e     state_q, state_d;
    logic          clk_s1_q, clk_s2_q, clk_s3_q;
    logic          dat_s1_q, dat_s2_q;
    logic          fall;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic          rx_valid, rx_err;
    logic          brk_q, brk_d, ext_q, ext_d;
    logic          push, pop, do_write, empty, full;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          armed_q, armed_d;
    logic          ferr_q, ovf_q, ovf_d;

    // Sync flops reset to 1 so a held-idle bus never looks like a falling edge.
    always_ff @(posedge CLK_CPU or posedge resetp) begin
        if (resetp) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            clk_s3_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            clk_s3_q <= clk_s2_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    assign fall = clk_s3_q & ~clk_s2_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tmo_d     = '0;
        rx_valid  = 1'b0;
        rx_err    = 1'b0;
        if (state_q != ST_IDLE) begin
            tmo_d = fall ? '0 : tmo_q + CW'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (fall && !dat_s2_q) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    parity_d = dat_s2_q;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    if (dat_s2_q && (^{shift_q, parity_q})) begin
                        rx_valid = 1'b1;
                    end else begin
                        rx_err = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A stalled keyboard must not leave the receiver stuck mid-frame.
        if ((state_q != ST_IDLE) && !fall && (tmo_q == CW'(TIMEOUT_CYCLES - 1))) begin
            rx_err  = 1'b1;
            state_d = ST_IDLE;
            tmo_d   = '0;
        end
    end

    always_comb begin
        brk_d = brk_q;
        ext_d = ext_q;
        push  = 1'b0;
        if (rx_valid) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push  = !brk_q;
                brk_d = 1'b0;
                ext_d = 1'b0;
            end
        end
    end

    // Pop handshake: clean_key_buffer=0 re-arms, so a held request pops only once.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop      = clean_key_buffer && !empty && armed_q;
    assign do_write = push && (!full || pop);
    assign ovf_d    = push && full && !pop;
    assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_write);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    assign armed_d  = pop ? 1'b0 : (!clean_key_buffer ? 1'b1 : armed_q);

    always_ff @(posedge CLK_CPU or posedge resetp) begin
        if (resetp) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            parity_q  <= 1'b0;
            tmo_q     <= '0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            armed_q   <= 1'b1;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tmo_q     <= tmo_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            armed_q   <= armed_d;
            ferr_q    <= rx_err;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge CLK_CPU) begin
        if (do_write) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    assign pressed_key    = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign keyboard_valid = !empty;
    assign frame_error    = ferr_q;
    assign overflow       = ovf_q;
    assign rx_state_o     = state_q;

endmodule

// File: tb/tb_ps2_key_buffer.sv
// Bench for ps2_key_buffer: directed PS/2 frames, a queue-based model of the
// key buffer checked every cycle, plus literal spot checks.
module tb_ps2_key_buffer;

    localparam int DEPTH = 4;
    localparam int T     = 64;
    localparam int H     = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk_pin, ps2_data_pin, clean;
    logic [7:0] pressed_key;
    logic       keyboard_valid, frame_error, overflow;
    logic [1:0] rx_state;

    ps2_key_buffer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(T)) dut (
        .CLK_CPU          (clk),
        .resetp           (rst),
        .ps2_clk          (ps2_clk_pin),
        .ps2_data         (ps2_data_pin),
        .clean_key_buffer (clean),
        .pressed_key      (pressed_key),
        .keyboard_valid   (keyboard_valid),
        .frame_error      (frame_error),
        .overflow         (overflow),
        .rx_state_o       (rx_state)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int last_fall_cyc = 0;

    // Model state: buffered codes plus frame-level events posted by the driver.
    logic [7:0] model_q[$];
    logic       m_armed = 1'b1;
    logic       m_brk = 1'b0;
    logic       m_exp_ferr = 1'b0;
    logic       m_exp_ovf = 1'b0;
    logic       m_ev_good = 1'b0;
    logic       m_ev_err = 1'b0;
    logic [7:0] m_ev_byte = 8'h00;
    logic       ferr_dc = 1'b0;
    logic       m_pop, m_push;
    int         m_size;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        model_q.delete();
        m_armed    = 1'b1;
        m_brk      = 1'b0;
        m_exp_ferr = 1'b0;
        m_exp_ovf  = 1'b0;
        m_ev_good  = 1'b0;
        m_ev_err   = 1'b0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            m_size     = model_q.size();
            m_pop      = clean && (m_size != 0) && m_armed;
            m_push     = 1'b0;
            m_exp_ferr = m_ev_err;
            m_exp_ovf  = 1'b0;
            if (m_pop) m_armed = 1'b0;
            else if (!clean) m_armed = 1'b1;
            if (m_ev_good) begin
                if (m_ev_byte == 8'hF0) m_brk = 1'b1;
                else if (m_ev_byte != 8'hE0) begin
                    m_push = !m_brk;
                    m_brk  = 1'b0;
                end
            end
            if (m_pop) void'(model_q.pop_front());
            if (m_push) begin
                if (m_size == DEPTH && !m_pop) m_exp_ovf = 1'b1;
                else model_q.push_back(m_ev_byte);
            end
            m_ev_good = 1'b0;
            m_ev_err  = 1'b0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        chk("keyboard_valid", {31'd0, keyboard_valid}, {31'd0, model_q.size() != 0});
        chk("pressed_key", {24'd0, pressed_key}, {24'd0, (model_q.size() != 0) ? model_q[0] : 8'h00});
        if (!ferr_dc) chk("frame_error", {31'd0, frame_error}, {31'd0, m_exp_ferr});
        chk("overflow", {31'd0, overflow}, {31'd0, m_exp_ovf});
    end

    task automatic ps2_bit(input logic b);
        ps2_data_pin = b;
        repeat (H) @(negedge clk);
        ps2_clk_pin   = 1'b0;
        last_fall_cyc = cyc;
        repeat (H) @(negedge clk);
        ps2_clk_pin = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_data_pin = ~bad_stop;
        repeat (H) @(negedge clk);
        ps2_clk_pin = 1'b0;
        repeat (2) @(negedge clk);
        if (bad_par || bad_stop) m_ev_err = 1'b1;
        else begin
            m_ev_good = 1'b1;
            m_ev_byte = b;
        end
        repeat (H - 2) @(negedge clk);
        ps2_clk_pin  = 1'b1;
        ps2_data_pin = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic pop_one();
        clean = 1'b1;
        @(negedge clk);
        clean = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        ps2_clk_pin  = 1'b1;
        ps2_data_pin = 1'b1;
        @(negedge clk);
        chk("rst_valid", {31'd0, keyboard_valid}, 32'd0);
        chk("rst_key", {24'd0, pressed_key}, 32'd0);
        chk("rst_ferr", {31'd0, frame_error}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] ovf_codes [5];
    int         ferr_cnt, ferr_at;

    initial begin
        ovf_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        rst = 1'b0; clean = 1'b0; ps2_clk_pin = 1'b1; ps2_data_pin = 1'b1;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        apply_reset();

        // Make code
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("make_key", {24'd0, pressed_key}, 32'h1C);
        chk("make_valid", {31'd0, keyboard_valid}, 32'd1);
        pop_one();

        // Break and extended sequences
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("break_empty", {31'd0, keyboard_valid}, 32'd0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        chk("ext_key", {24'd0, pressed_key}, 32'h75);
        pop_one();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        chk("ext_break_empty", {31'd0, keyboard_valid}, 32'd0);

        // Parity and stop errors
        send_frame(8'h1C, 1'b1, 1'b0);
        chk("par_err_empty", {31'd0, keyboard_valid}, 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("stop_err_empty", {31'd0, keyboard_valid}, 32'd0);

        // Overflow, then drain in order
        for (int i = 0; i < 5; i++) send_frame(ovf_codes[i], 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_key", {24'd0, pressed_key}, {24'd0, ovf_codes[i]});
            pop_one();
        end
        chk("drain_empty", {31'd0, keyboard_valid}, 32'd0);

        // Held pop request pops exactly once
        send_frame(8'h15, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        clean = 1'b1;
        repeat (10) @(negedge clk);
        clean = 1'b0;
        @(negedge clk);
        chk("held_pop_key", {24'd0, pressed_key}, 32'h1D);
        chk("held_pop_valid", {31'd0, keyboard_valid}, 32'd1);
        pop_one();

        // Request raised while empty pops the next arrival
        clean = 1'b1;
        send_frame(8'h24, 1'b0, 1'b0);
        chk("early_pop_empty", {31'd0, keyboard_valid}, 32'd0);
        clean = 1'b0;
        @(negedge clk);

        // Timeout on a truncated frame
        ferr_dc = 1'b1;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ferr_cnt = 0;
        ferr_at  = 0;
        for (int i = 0; i < T + 20; i++) begin
            @(negedge clk);
            if (frame_error === 1'b1) begin
                ferr_cnt++;
                ferr_at = cyc;
            end
        end
        chk("timeout_pulses", ferr_cnt, 32'd1);
        chk("timeout_late", {31'd0, (ferr_at > last_fall_cyc + T + 6)}, 32'd0);
        chk("timeout_early", {31'd0, (ferr_at < last_fall_cyc + T)}, 32'd0);
        ferr_dc = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("after_timeout_key", {24'd0, pressed_key}, 32'h1C);
        pop_one();

        // Reset mid-frame with two entries buffered
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h2D, 1'b0, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        apply_reset();
        send_frame(8'h24, 1'b0, 1'b0);
        chk("after_reset_key", {24'd0, pressed_key}, 32'h24);
        chk("after_reset_valid", {31'd0, keyboard_valid}, 32'd1);
        pop_one();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
